// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Sequences the MFCC framing stage. Pre-emphasised samples are written into a
// circular sample RAM. Once a full frame is stored, the frame is replayed to
// the windowing/FFT path with a per-sample window index and SOF/EOF markers.
// The frame base then advances by the hop (frame_size - frame_overlap).
//
// Optional feature (compile-time macro FRAME_SCHED_STATS_EN):
//   adds the frame_count and drop_count saturating statistics outputs.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   enable         run control; a rising edge in IDLE latches the config
//   frame_size     samples per frame (1..255)
//   frame_overlap  samples shared between consecutive frames (< frame_size)
//   sample_in      pre-emphasised sample
//   sample_valid   sample strobe (upstream cannot be stalled)
//   out_data       frame sample
//   out_idx        position of the sample within its frame (window ROM index)
//   out_sof        first sample of a frame
//   out_eof        last sample of a frame
//   out_valid      output qualifier
//   out_ready      downstream accept
//   busy           scheduler is not idle
//   cfg_error      sticky; the last latched config was illegal
//   overrun        sticky; a sample was dropped because the ring was full
//   frame_count    (stats only) frames fully accepted downstream, saturating
//   drop_count     (stats only) samples dropped on overrun, saturating
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [7:0]        frame_size,
    input  logic [7:0]        frame_overlap,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_idx,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              cfg_error,
    output logic              overrun
`ifdef FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count
`endif
);

    // Pointers carry one extra bit so that a completely full ring
    // (occupancy == depth) can be told apart from an empty one.
    localparam int                PTR_W      = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  RING_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] ring [0:(1<<ADDR_W)-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  frame_base;
    logic [7:0]        fs_q;
    logic [7:0]        ov_q;
    logic [7:0]        rd_idx;
    logic              enable_q;

    logic [PTR_W-1:0]  occupancy;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  hop;
    logic              ring_full;
    logic              do_write;
    logic              do_drop;
    logic              do_read;
    logic              out_accept;
    logic              eof_accept;
    logic              cfg_ok;
    logic              cfg_edge;
    logic              frame_ready;

    // NOTE: every signal assigned in an always_comb block gets a value on
    // every path (here unconditionally); a missing default infers a latch.
    always_comb begin
        occupancy   = wr_ptr - frame_base;
        ring_full   = (occupancy == RING_DEPTH);
        do_write    = sample_valid && (state != S_IDLE) && !ring_full;
        do_drop     = sample_valid && (state != S_IDLE) && ring_full;
        out_accept  = out_valid && out_ready;
        eof_accept  = out_accept && out_eof;
        // A new read may be issued only if the output register is free
        // now or is emptied by an accept in this same cycle.
        do_read     = (state == S_EMIT) && (!out_valid || out_accept);
        rd_ptr      = frame_base + PTR_W'(rd_idx);
        hop         = PTR_W'(fs_q - ov_q);
        cfg_ok      = (frame_size != 8'd0) && (frame_overlap < frame_size);
        cfg_edge    = (state == S_IDLE) && enable && !enable_q;
        // Occupancy counts the whole current frame, so the samples being
        // replayed can never be overwritten by concurrent writes.
        frame_ready = (occupancy >= PTR_W'(fs_q));
    end

    assign busy = (state != S_IDLE);

    // NOTE: the sample ring is storage, not control state; it has no reset so
    // it maps onto RAM, and nothing reads a location before it is written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            ring[wr_ptr[ADDR_W-1:0]] <= sample_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every read
    // in this block sees the pre-edge value. Later assignments in the block
    // deliberately override earlier ones (pointer clears beat increments).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            frame_base <= '0;
            fs_q       <= '0;
            ov_q       <= '0;
            rd_idx     <= '0;
            enable_q   <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_valid  <= 1'b0;
            cfg_error  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            enable_q <= enable;

            // Write side.
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_drop) begin
                overrun <= 1'b1;
            end

            // Output register: the ring read lands here directly, so data,
            // index and markers always load together with out_valid.
            if (do_read) begin
                out_valid <= 1'b1;
                out_data  <= ring[rd_ptr[ADDR_W-1:0]];
                out_idx   <= rd_idx;
                out_sof   <= (rd_idx == 8'd0);
                out_eof   <= (rd_idx == fs_q - 8'd1);
            end else if (out_accept) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (cfg_edge) begin
                        fs_q <= frame_size;
                        ov_q <= frame_overlap;
                        if (cfg_ok) begin
                            cfg_error <= 1'b0;
                            state     <= S_FILL;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (!enable) begin
                        state      <= S_IDLE;
                        wr_ptr     <= '0;
                        frame_base <= '0;
                    end else if (frame_ready) begin
                        rd_idx <= 8'd0;
                        state  <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (do_read) begin
                        rd_idx <= rd_idx + 8'd1;
                        if (rd_idx == fs_q - 8'd1) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // The frame only retires once its last sample has been
                    // taken; enable dropping mid-frame never truncates.
                    if (eof_accept) begin
                        if (enable) begin
                            frame_base <= frame_base + hop;
                            state      <= S_FILL;
                        end else begin
                            wr_ptr     <= '0;
                            frame_base <= '0;
                            state      <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else if (cfg_edge && cfg_ok) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (eof_accept && (frame_count != 16'hFFFF)) begin
                frame_count <= frame_count + 16'd1;
            end
            if (do_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Self-checking bench for frame_scheduler. A table of configurations is run
// through a common procedure; hand-written sequences then cover first-output
// latency, enable deassertion mid-frame, ring overrun and reset during EMIT.
// Inputs change 2 time units after the rising edge; the output monitor
// samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [7:0]        frame_size;
    logic [7:0]        frame_overlap;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_idx;
    logic              out_sof;
    logic              out_eof;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              cfg_error;
    logic              overrun;
`ifdef FRAME_SCHED_STATS_EN
    logic [15:0]       frame_count;
    logic [15:0]       drop_count;
`endif

    always #5 clk = ~clk;

    frame_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_size   (frame_size),
        .frame_overlap(frame_overlap),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .cfg_error    (cfg_error),
        .overrun      (overrun)
`ifdef FRAME_SCHED_STATS_EN
        ,
        .frame_count  (frame_count),
        .drop_count   (drop_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready
    int ready_mode = 0;
    int ready_cyc  = 0;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((ready_cyc % 4) == 0) || ((ready_cyc % 4) == 3);
            default: out_ready = 1'b0;
        endcase
        ready_cyc++;
    end

    // Accepted outputs packed as {sof, eof, idx, data}.
    logic [25:0] acc[$];
    logic        hold_chk = 1'b0;
    logic [25:0] hold_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_sof, out_eof, out_idx, out_data}), 32'(hold_val));
            end
            if (out_valid && out_ready) begin
                acc.push_back({out_sof, out_eof, out_idx, out_data});
            end
            hold_chk = out_valid && !out_ready;
            hold_val = {out_sof, out_eof, out_idx, out_data};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            sample_in    = DATA_W'(base + i);
            sample_valid = 1'b1;
            tick(1);
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_acc(input int target, input string tag);
        for (int k = 0; k < 600 && acc.size() < target; k++) tick(1);
        tick(10);
        check({tag, "_count"}, 32'(acc.size()), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200 && busy; k++) tick(1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Reference frame content: frame k, position i holds base + k*hop + i.
    task automatic check_frames(input int fs, input int ov, input int base,
                                input int nframes, input string tag);
        logic [25:0] exp;
        int          j;
        j = 0;
        for (int k = 0; k < nframes; k++) begin
            for (int i = 0; i < fs; i++) begin
                exp = {(i == 0), (i == fs - 1), 8'(i), 16'(base + k * (fs - ov) + i)};
                if (j < acc.size()) begin
                    check($sformatf("%s_f%0d_i%0d", tag, k, i), 32'(acc[j]), 32'(exp));
                end
                j++;
            end
        end
    endtask

    typedef struct {
        int fs;
        int ov;
        int n;
        int base;
        int mode;
        int err;
        int frames;
    } case_t;

    case_t cases[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cases[0] = '{fs: 8, ov: 4, n: 16, base: 0,   mode: 0, err: 0, frames: 3};
        cases[1] = '{fs: 8, ov: 4, n: 16, base: 0,   mode: 1, err: 0, frames: 3};
        cases[2] = '{fs: 8, ov: 8, n: 4,  base: 0,   mode: 0, err: 1, frames: 0};
        cases[3] = '{fs: 4, ov: 0, n: 8,  base: 0,   mode: 0, err: 0, frames: 2};
        cases[4] = '{fs: 1, ov: 0, n: 5,  base: 40,  mode: 0, err: 0, frames: 5};
        cases[5] = '{fs: 8, ov: 7, n: 10, base: 200, mode: 0, err: 0, frames: 3};
        cases[6] = '{fs: 0, ov: 0, n: 4,  base: 0,   mode: 0, err: 1, frames: 0};
        cases[7] = '{fs: 5, ov: 2, n: 11, base: 300, mode: 1, err: 0, frames: 3};

        rst_n         = 1'b0;
        enable        = 1'b0;
        frame_size    = 8'd0;
        frame_overlap = 8'd0;
        sample_in     = '0;
        sample_valid  = 1'b0;
        out_ready     = 1'b1;
        tick(3);

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_error", 32'(cfg_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // ---------------- table-driven configurations ----------------
        for (int c = 0; c < 8; c++) begin
            tick(2);
            ready_mode    = cases[c].mode;
            frame_size    = 8'(cases[c].fs);
            frame_overlap = 8'(cases[c].ov);
            enable        = 1'b1;
            acc.delete();
            tick(2);
            check($sformatf("c%0d_cfg_error", c), 32'(cfg_error), 32'(cases[c].err));
            check($sformatf("c%0d_busy", c), 32'(busy), 32'(cases[c].err == 0));
            feed(cases[c].n, cases[c].base);
            if (cases[c].err != 0) begin
                tick(10);
                check($sformatf("c%0d_no_output", c), 32'(acc.size()), 32'd0);
                check($sformatf("c%0d_no_overrun", c), 32'(overrun), 32'd0);
            end else begin
                wait_acc(cases[c].frames * cases[c].fs, $sformatf("c%0d", c));
                check_frames(cases[c].fs, cases[c].ov, cases[c].base,
                             cases[c].frames, $sformatf("c%0d", c));
`ifdef FRAME_SCHED_STATS_EN
                check($sformatf("c%0d_frame_count", c), 32'(frame_count), 32'(cases[c].frames));
`endif
            end
            enable = 1'b0;
            wait_idle($sformatf("c%0d", c));
        end
        ready_mode = 0;

        // ---------------- first-output latency ----------------
        tick(2);
        frame_size    = 8'd4;
        frame_overlap = 8'd0;
        enable        = 1'b1;
        tick(2);
        acc.delete();
        feed(3, 20);
        sample_in    = 16'd23;
        sample_valid = 1'b1;
        @(posedge clk);                 // write making occupancy == FS
        #1;
        check("lat_e0_valid", 32'(out_valid), 32'd0);
        #1;
        sample_valid = 1'b0;
        @(posedge clk);                 // FILL -> EMIT
        #1;
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);                 // read lands in output register
        #1;
        check("lat_e2_valid", 32'(out_valid), 32'd1);
        check("lat_e2_data", 32'(out_data), 32'd20);
        check("lat_e2_sof", 32'(out_sof), 32'd1);
        #1;
        wait_acc(4, "lat");
        check_frames(4, 0, 20, 1, "lat");
        enable = 1'b0;
        wait_idle("lat");

        // ---------------- enable dropped mid-frame ----------------
        begin
            logic found;
            tick(2);
            frame_size    = 8'd8;
            frame_overlap = 8'd2;
            enable        = 1'b1;
            tick(2);
            acc.delete();
            feed(14, 0);
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                @(negedge clk);
                if (out_valid && out_idx == 8'd3 && acc.size() >= 8) found = 1'b1;
            end
            check("drop_found_idx3", 32'(found), 32'd1);
            enable = 1'b0;
            tick(1);
            wait_idle("drop");
            check("drop_count_frames", 32'(acc.size()), 32'd16);
            check_frames(8, 2, 0, 2, "drop");
            check("drop_out_valid", 32'(out_valid), 32'd0);

            tick(2);
            enable = 1'b1;
            tick(2);
            acc.delete();
            feed(8, 100);
            wait_acc(8, "reen");
            check_frames(8, 2, 100, 1, "reen");
            enable = 1'b0;
            wait_idle("reen");
        end

        // ---------------- overrun ----------------
        tick(2);
        ready_mode    = 2;
        frame_size    = 8'd255;
        frame_overlap = 8'd254;
        enable        = 1'b1;
        tick(2);
        acc.delete();
        feed(256, 0);
        check("ovr_before_full", 32'(overrun), 32'd0);
        feed(1, 256);
        check("ovr_first_drop", 32'(overrun), 32'd1);
        feed(43, 257);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_out_valid", 32'(out_valid), 32'd1);
        check("ovr_out_data", 32'(out_data), 32'd0);
        check("ovr_out_idx", 32'(out_idx), 32'd0);
        check("ovr_out_sof", 32'(out_sof), 32'd1);
        check("ovr_no_accept", 32'(acc.size()), 32'd0);
`ifdef FRAME_SCHED_STATS_EN
        check("ovr_drop_count", 32'(drop_count), 32'd44);
        check("ovr_frame_count", 32'(frame_count), 32'd0);
`endif

        // ---------------- reset during EMIT ----------------
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("rstm_out_valid", 32'(out_valid), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_overrun", 32'(overrun), 32'd0);
        tick(1);
        rst_n      = 1'b1;
        ready_mode = 0;
        tick(2);
        check("rstm_busy_after", 32'(busy), 32'd0);
        check("rstm_cfg_error_after", 32'(cfg_error), 32'd0);
        frame_size    = 8'd4;
        frame_overlap = 8'd0;
        enable        = 1'b1;
        tick(2);
        check("rstm_restart_busy", 32'(busy), 32'd1);
        acc.delete();
        feed(4, 50);
        wait_acc(4, "rstm");
        check_frames(4, 0, 50, 1, "rstm");
`ifdef FRAME_SCHED_STATS_EN
        check("rstm_frame_count", 32'(frame_count), 32'd1);
        check("rstm_drop_count", 32'(drop_count), 32'd0);
`endif
        enable = 1'b0;
        wait_idle("rstm");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
